dmem_mmio: RTL and testbench

Data-side memory subsystem for the single-cycle MIPS core: consumes the core's data port (`memwrite`, ALU address, `writedata`) and returns `readdata` in the same cycle. Decodes the address into a word-addressed data RAM and a memory-mapped peripheral page holding LED output, synchronized switch input and a compare-match timer with interrupt. Sits directly downstream of the core's data port in the top-level, alongside the instruction memory.

---
 rtl/dmem_mmio_if.sv | 22 ++
 rtl/dmem_mmio.sv | 159 +++++++++++++++
 tb/tb_dmem_mmio.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_if.sv
// Data-port bundle between the core and dmem_mmio.
// The core drives the master side; the memory subsystem is the slave.
interface dmem_mmio_if;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output memwrite,
      output addr,
      output writedata,
      input  readdata
   );

   modport slave (
      input  memwrite,
      input  addr,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/dmem_mmio.sv
// Data RAM plus LED/switch/timer MMIO page for the single-cycle core.
// Define DMEM_MMIO_TIMER_EN to build the compare-match timer and irq.
module dmem_mmio #(
   parameter int RAM_WORDS = 64,
   parameter int IO_W      = 16
) (
   input  logic            clk,
   input  logic            reset,
   dmem_mmio_if.slave      bus,
   input  logic [IO_W-1:0] switches,
   output logic [IO_W-1:0] leds,
   output logic            irq
);
   localparam int AW = $clog2(RAM_WORDS);

   localparam logic [31:0] A_LED = 32'h0000_FF00;
   localparam logic [31:0] A_SW  = 32'h0000_FF04;
`ifdef DMEM_MMIO_TIMER_EN
   localparam logic [31:0] A_TCNT = 32'h0000_FF08;
   localparam logic [31:0] A_TCMP = 32'h0000_FF0C;
   localparam logic [31:0] A_TCTL = 32'h0000_FF10;
   localparam logic [31:0] A_TSTA = 32'h0000_FF14;
`endif

   logic [31:0]     ram_q [RAM_WORDS];
   logic [IO_W-1:0] leds_q, leds_d;
   logic [IO_W-1:0] sync1_q, sync2_q;

   logic [31:0]   word_a;
   logic [AW-1:0] ram_idx;
   logic          ram_hit;
   logic          we;
   logic          sel_led, sel_sw;
   logic          unused_lsb;

   assign word_a     = {bus.addr[31:2], 2'b00};
   assign ram_idx    = bus.addr[AW+1:2];
   assign ram_hit    = (bus.addr[31:AW+2] == '0);
   assign sel_led    = (word_a == A_LED);
   assign sel_sw     = (word_a == A_SW);
   assign unused_lsb = ^bus.addr[1:0];

   // Writes issued in a reset cycle are dropped, RAM included.
   assign we = bus.memwrite & ~reset;

   always_ff @(posedge clk) begin
      if (we && ram_hit) begin
         ram_q[ram_idx] <= bus.writedata;
      end
   end

   always_comb begin
      leds_d = leds_q;
      if (we && sel_led) begin
         leds_d = bus.writedata[IO_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         leds_q  <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         leds_q  <= leds_d;
         sync1_q <= switches;
         sync2_q <= sync1_q;
      end
   end

   assign leds = leds_q;

`ifdef DMEM_MMIO_TIMER_EN
   logic [31:0] tcnt_q, tcnt_d;
   logic [31:0] tcmp_q, tcmp_d;
   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        flag_q, flag_d;
   logic        irq_q, irq_d;
   logic        match;
   logic        sel_tcnt, sel_tcmp, sel_tctl, sel_tsta;

   assign sel_tcnt = (word_a == A_TCNT);
   assign sel_tcmp = (word_a == A_TCMP);
   assign sel_tctl = (word_a == A_TCTL);
   assign sel_tsta = (word_a == A_TSTA);
   assign match    = en_q && (tcnt_q == tcmp_q);

   always_comb begin
      tcnt_d = tcnt_q;
      tcmp_d = tcmp_q;
      en_d   = en_q;
      ie_d   = ie_q;
      flag_d = flag_q;
      if (en_q) begin
         tcnt_d = match ? 32'd0 : tcnt_q + 32'd1;
      end
      if (we && sel_tcnt) tcnt_d = bus.writedata;
      if (we && sel_tcmp) tcmp_d = bus.writedata;
      if (we && sel_tctl) begin
         en_d = bus.writedata[0];
         ie_d = bus.writedata[1];
      end
      if (we && sel_tsta && bus.writedata[0]) begin
         flag_d = 1'b0;
      end
      // A match in the clear cycle keeps the flag set.
      if (match) flag_d = 1'b1;
      irq_d = flag_q & ie_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt_q <= '0;
         tcmp_q <= '1;
         en_q   <= 1'b0;
         ie_q   <= 1'b0;
         flag_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         tcnt_q <= tcnt_d;
         tcmp_q <= tcmp_d;
         en_q   <= en_d;
         ie_q   <= ie_d;
         flag_q <= flag_d;
         irq_q  <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   logic [31:0] led_ext, sw_ext;

   always_comb begin
      led_ext = '0;
      sw_ext  = '0;
      led_ext[IO_W-1:0] = leds_q;
      sw_ext[IO_W-1:0]  = sync2_q;
   end

   always_comb begin
      bus.readdata = '0;
      unique case (1'b1)
         ram_hit:  bus.readdata = ram_q[ram_idx];
         sel_led:  bus.readdata = led_ext;
         sel_sw:   bus.readdata = sw_ext;
`ifdef DMEM_MMIO_TIMER_EN
         sel_tcnt: bus.readdata = tcnt_q;
         sel_tcmp: bus.readdata = tcmp_q;
         sel_tctl: bus.readdata = {30'd0, ie_q, en_q};
         sel_tsta: bus.readdata = {31'd0, flag_q};
`endif
         default:  bus.readdata = '0;
      endcase
   end
endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio; timer checks follow DMEM_MMIO_TIMER_EN.
// Stimulus queues expectations, a negedge monitor pops and compares.
module tb_dmem_mmio;
  logic        clk;
  logic        reset;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        irq;

  dmem_mmio_if bus ();

  dmem_mmio #(
    .RAM_WORDS(64),
    .IO_W     (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .switches(switches),
    .leds    (leds),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t       sb[$];
  item_t       it;
  logic [31:0] act;
  int          checks   = 0;
  int          failures = 0;
  bit          done     = 1'b0;

  localparam int K_RD  = 0;
  localparam int K_LED = 1;
  localparam int K_IRQ = 2;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.kind)
        K_RD:    act = bus.readdata;
        K_LED:   act = 32'(leds);
        default: act = {31'd0, irq};
      endcase
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h",
                 it.name, act, it.exp);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: stimulus did not finish");
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
    end
  end

  task automatic drive(input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    bus.memwrite  = we;
    bus.addr      = a;
    bus.writedata = d;
  endtask

  task automatic push(input int k, input logic [31:0] v,
                      input string n);
    item_t e;
    e.kind = k;
    e.exp  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, a, d);
    step();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v,
                    input string n);
    drive(1'b0, a, 32'd0);
    push(K_RD, v, n);
    step();
  endtask

  initial begin
    reset    = 1'b1;
    switches = '0;
    drive(1'b0, 32'h0000_FF00, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (leds !== 16'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rst_direct: leds=0x%04h irq=%b", leds, irq);
    end
    push(K_LED, 32'd0, "rst_leds");
    push(K_IRQ, 32'd0, "rst_irq");
    rd(32'h0000_FF00, 32'd0, "rst_led_rd");
    rd(32'h0000_FF04, 32'd0, "rst_sw_rd");

    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h14, 32'h1234_5678);
    rd(32'h10, 32'hDEAD_BEEF, "ram_10");
    rd(32'h14, 32'h1234_5678, "ram_14");
    rd(32'h11, 32'hDEAD_BEEF, "ram_11_lsb");
    wr(32'h00, 32'h0000_AAAA);
    wr(32'hFC, 32'hCAFE_F00D);
    wr(32'h100, 32'h5555_5555);
    rd(32'h00, 32'h0000_AAAA, "ram_0_noalias");
    rd(32'hFC, 32'hCAFE_F00D, "ram_last");
    rd(32'h100, 32'd0, "ram_past_end");

    wr(32'h0000_FF00, 32'hFFFF_A5A5);
    push(K_LED, 32'h0000_A5A5, "led_port");
    rd(32'h0000_FF00, 32'h0000_A5A5, "led_rd");

    switches = 16'h003C;
    rd(32'h0000_FF04, 32'd0, "sw_0edge");
    rd(32'h0000_FF04, 32'd0, "sw_1edge");
    rd(32'h0000_FF04, 32'h0000_003C, "sw_2edge");

    rd(32'h0000_8000, 32'd0, "unmap_8000");
    rd(32'h0001_FF00, 32'd0, "unmap_hi_led");
    rd(32'h0000_FF18, 32'd0, "unmap_ff18");

`ifdef DMEM_MMIO_TIMER_EN
    wr(32'h0000_FF0C, 32'd3);
    wr(32'h0000_FF10, 32'd3);
    rd(32'h0000_FF08, 32'd0, "tcnt_0");
    rd(32'h0000_FF08, 32'd1, "tcnt_1");
    rd(32'h0000_FF08, 32'd2, "tcnt_2");
    rd(32'h0000_FF08, 32'd3, "tcnt_3");
    push(K_IRQ, 32'd0, "irq_lag");
    rd(32'h0000_FF08, 32'd0, "tcnt_reload");
    drive(1'b1, 32'h0000_FF14, 32'd1);
    push(K_IRQ, 32'd1, "irq_set");
    push(K_RD, 32'd1, "flag_set");
    step();
    push(K_IRQ, 32'd1, "irq_hold");
    rd(32'h0000_FF14, 32'd0, "flag_clr");
    drive(1'b1, 32'h0000_FF14, 32'd1);
    push(K_IRQ, 32'd0, "irq_clr");
    push(K_RD, 32'd0, "flag_pre_match");
    step();
    rd(32'h0000_FF14, 32'd1, "flag_set_wins");
    drive(1'b1, 32'h0000_FF08, 32'd100);
    push(K_RD, 32'd1, "tcnt_prewrite");
    push(K_IRQ, 32'd1, "irq_again");
    step();
    rd(32'h0000_FF08, 32'd100, "tcnt_wr_wins");
    rd(32'h0000_FF08, 32'd101, "tcnt_after_wr");

    wr(32'h0000_FF10, 32'd0);
    wr(32'h0000_FF0C, 32'd5);
    wr(32'h0000_FF08, 32'hFFFF_FFFE);
    wr(32'h0000_FF14, 32'd1);
    wr(32'h0000_FF10, 32'd1);
    rd(32'h0000_FF08, 32'hFFFF_FFFE, "wrap_fe");
    rd(32'h0000_FF08, 32'hFFFF_FFFF, "wrap_ff");
    rd(32'h0000_FF08, 32'd0, "wrap_0");
    push(K_IRQ, 32'd0, "wrap_irq");
    rd(32'h0000_FF14, 32'd0, "wrap_noflag");
`else
    wr(32'h0000_FF08, 32'd55);
    wr(32'h0000_FF10, 32'd3);
    rd(32'h0000_FF08, 32'd0, "notmr_tcnt");
    rd(32'h0000_FF0C, 32'd0, "notmr_tcmp");
    rd(32'h0000_FF10, 32'd0, "notmr_tctl");
    push(K_IRQ, 32'd0, "notmr_irq");
    rd(32'h0000_FF14, 32'd0, "notmr_tsta");
`endif

    wr(32'h20, 32'h0000_1111);
    wr(32'h0000_FF00, 32'h0000_1234);
`ifdef DMEM_MMIO_TIMER_EN
    wr(32'h0000_FF10, 32'd0);
    wr(32'h0000_FF0C, 32'd2);
    wr(32'h0000_FF08, 32'd0);
    wr(32'h0000_FF10, 32'd3);
    repeat (4) step();
    wr(32'h0000_FF0C, 32'd100);
    wr(32'h0000_FF08, 32'd5);
    rd(32'h0000_FF08, 32'd5, "mid_5");
    rd(32'h0000_FF08, 32'd6, "mid_6");
    push(K_IRQ, 32'd1, "pre_rst_irq");
`endif
    drive(1'b1, 32'h20, 32'h0000_0BAD);
    reset = 1'b1;
    push(K_LED, 32'h0000_1234, "pre_rst_leds");
    push(K_RD, 32'h0000_1111, "pre_rst_ram");
    step();
    reset = 1'b0;
    push(K_LED, 32'd0, "post_rst_leds");
    push(K_IRQ, 32'd0, "post_rst_irq");
    rd(32'h0000_FF08, 32'd0, "post_rst_tcnt");
    rd(32'h20, 32'h0000_1111, "rst_ram_wr_dropped");
`ifdef DMEM_MMIO_TIMER_EN
    rd(32'h0000_FF10, 32'd0, "post_rst_tctl");
    rd(32'h0000_FF0C, 32'hFFFF_FFFF, "post_rst_tcmp");
    rd(32'h0000_FF14, 32'd0, "post_rst_flag");
    rd(32'h0000_FF08, 32'd0, "post_rst_hold");
`else
    push(K_IRQ, 32'd0, "notmr_irq_end");
    rd(32'h0000_FF0C, 32'd0, "notmr_tcmp_end");
`endif

    step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d items left", sb.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
